aemb_wb_timer: RTL and testbench
================================

Name: aemb_wb_timer

Overview:
- Synthesizable Wishbone slave timer/interrupt source on the AEMB2 data bus (dwb), directly downstream of the core's dwb master port.
- Drives the core's sys_int_i.
- Replaces the simulation-only free-running fake timer and the interrupt-toggle port with real RTL.
- Provides a 32-bit down-counter with reload, one-shot/auto-reload modes, a sticky interrupt-pending flag and a maskable interrupt output.

Parameters:
- CNT_W, 32, counter and LOAD register width (8..32); unused upper bits of CNT/LOAD read 0.
- RST_LOAD, 32'h0000_7FFF, reset value of LOAD and CNT (32k ticks).

Ports:
- sys_clk_i  in  1  system clock, all state on rising edge.
- sys_rst_i  in  1  reset; one clock; asynchronous, active-low.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe (chip select, decoded externally).
- wb_wre_i  in  1  1 = write, 0 = read.
- wb_sel_i  in  4  byte lanes, big-endian AEMB order (sel[3] = dat[31:24]).
- wb_adr_i  in  2  word address bits [3:2].
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  transfer acknowledge.
- sys_int_o  out  1  level interrupt to core = PEND & IEN.

Behaviour:

Register map (wb_adr_i):
- 0 CTRL: [0] EN, [1] IEN, [2] AUTO, [15:8] PRE (see Optional Feature); other bits read 0.
- 1 LOAD: reload value.
- 2 CNT: current count. Writable.
- 3 STAT: [0] PEND. Write 1 to clear, write 0 has no effect.

Reset (sys_rst_i low, asynchronous):
- CTRL = 0, PEND = 0, LOAD = CNT = RST_LOAD, prescaler = 0.
- wb_ack_o = 0, wb_dat_o = 0, sys_int_o = 0.

Handshake:
- wb_ack_o <= cyc & stb & !wb_ack_o. One cycle latency; ack is a single-cycle pulse.
- Back-to-back strobes are acked every other cycle.
- Writes commit on the edge where cyc & stb & wre & ack is high. Only lanes with wb_sel_i set are updated.
- Any sel pattern is accepted, including 0 (no-op).
- Reads: wb_dat_o is loaded with the addressed register on the same edge ack rises, and holds until the next read.
- Reads have no side effects.

Counting:
- tick = EN & prescaler terminal (every cycle when the prescaler is absent).
- On a tick with CNT != 0: CNT <= CNT - 1.
- On a tick with CNT == 0:
  - PEND <= 1 and CNT <= LOAD.
  - If AUTO = 0, EN <= 0 (one-shot stops after reload).
- LOAD = 0 with AUTO = 1 raises PEND on every tick.
- EN = 0 freezes CNT and the prescaler.

Simultaneous events:
- A bus write to CNT on a tick edge: the write wins and that decrement is lost.
- A bus write to CTRL on an expiry edge: the written EN value wins.
- STAT clear and expiry on the same edge: the set wins, so PEND = 1.
- Writing LOAD does not affect CNT until the next reload.

Interrupt output:
- sys_int_o is registered: sys_int_o <= PEND_next & IEN_next.
- It rises one cycle after expiry and stays high until PEND is cleared or IEN is cleared.

Reset mid-transaction:
- An asynchronous assert clears ack immediately.
- A write in flight is lost.

Optional Feature:
- Macro: AEMB_TMR_PRESCALE_EN.
- Defined: an 8-bit prescaler counts 0..PRE and produces a tick on reaching PRE, then wraps to 0. Tick period = PRE+1 cycles. PRE = 0 gives a tick every cycle. Writing CTRL resets the prescaler to 0.
- Undefined: no prescaler logic; tick = EN; CTRL[15:8] is not stored and reads 0.

Test Plan:
- Reset: hold sys_rst_i low mid-cycle -> all outputs 0 immediately; read LOAD -> 0000_7FFF; read CTRL -> 0000_0000; ack arrives exactly 1 cycle after stb.
- One-shot: write LOAD = 5, CNT = 5, CTRL = 3 -> PEND set 6 ticks after enable; sys_int_o high on the next cycle; CTRL reads 0000_0002 (EN cleared); CNT reads 5.
- Auto-reload: LOAD = 3, CTRL = 7 -> sys_int_o stays high; clear STAT each expiry -> PEND re-asserts every 4 ticks; write STAT = 1 on the expiry edge -> PEND stays 1.
- Byte lanes: write CNT = AABBCCDD with sel = 4'h3 over CNT = 11223344 (EN = 0) -> reads 1122CCDD; sel = 0 -> unchanged.
- Collision: while EN = 1, write CNT = 100 on a tick edge -> next read 100 followed by a decrement to 99 one tick later; IEN = 0 with PEND = 1 -> sys_int_o = 0.
- Prescaler (macro defined): PRE = 3, LOAD = 1, CNT = 1, CTRL = 0x0000_0307 -> PEND after 8 cycles. Macro undefined: same write reads back CTRL = 0000_0007.

Source files
------------

// File: rtl/aemb_wb_timer.sv
// AEMB2 dwb Wishbone slave timer: down-counter with reload, one-shot/auto modes and maskable IRQ.
// Optional 8-bit tick prescaler in CTRL[15:8] is built when AEMB_TMR_PRESCALE_EN is defined.
module aemb_wb_timer #(
    parameter int          CNT_W    = 32,
    parameter logic [31:0] RST_LOAD = 32'h0000_7FFF
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_wre_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        sys_int_o
);

    typedef enum logic [1:0] {
        ADR_CTRL = 2'd0,
        ADR_LOAD = 2'd1,
        ADR_CNT  = 2'd2,
        ADR_STAT = 2'd3
    } reg_adr_e;

    localparam logic [CNT_W-1:0] RST_CNT = RST_LOAD[CNT_W-1:0];

    // Byte-lane merge; sel[3] selects dat[31:24] in AEMB big-endian lane order.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] m;
        m = old_v;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) m[8*i +: 8] = new_v[8*i +: 8];
        end
        return m;
    endfunction

    logic             ack_q,  ack_d;
    logic [31:0]      dat_q,  dat_d;
    logic             int_q,  int_d;
    logic             en_q,   en_d;
    logic             ien_q,  ien_d;
    logic             auto_q, auto_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    logic             wr_commit;
    logic             tick;
    logic             expire;
    logic             pend_clr;
    logic [31:0]      ctrl_rd;
    logic [31:0]      rd_data;

`ifdef AEMB_TMR_PRESCALE_EN
    logic [7:0] pre_q, pre_d;
    logic [7:0] psc_q, psc_d;

    assign tick    = en_q & (psc_q == pre_q);
    assign ctrl_rd = {16'h0, pre_q, 5'h0, auto_q, ien_q, en_q};
`else
    assign tick    = en_q;
    assign ctrl_rd = {29'h0, auto_q, ien_q, en_q};
`endif

    assign wr_commit = wb_cyc_i & wb_stb_i & wb_wre_i & ack_q;
    assign expire    = tick & (cnt_q == '0);
    assign pend_clr  = wr_commit & (wb_adr_i == ADR_STAT) & wb_sel_i[0] & wb_dat_i[0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ack_d  = wb_cyc_i & wb_stb_i & ~ack_q;
        dat_d  = dat_q;
        en_d   = en_q;
        ien_d  = ien_q;
        auto_d = auto_q;
        load_d = load_q;
        cnt_d  = cnt_q;
`ifdef AEMB_TMR_PRESCALE_EN
        pre_d  = pre_q;
        psc_d  = psc_q;
        if (en_q) psc_d = (psc_q == pre_q) ? 8'h00 : psc_q + 8'h01;
`endif

        case (reg_adr_e'(wb_adr_i))
            ADR_CTRL: rd_data = ctrl_rd;
            ADR_LOAD: rd_data = 32'(load_q);
            ADR_CNT:  rd_data = 32'(cnt_q);
            default:  rd_data = {31'h0, pend_q};
        endcase
        if (ack_d & ~wb_wre_i) dat_d = rd_data;

        if (tick) begin
            if (cnt_q == '0) begin
                cnt_d = load_q;
                if (!auto_q) en_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        // Bus writes come after the tick update so they override it on a shared edge.
        if (wr_commit) begin
            case (reg_adr_e'(wb_adr_i))
                ADR_CTRL: begin
                    if (wb_sel_i[0]) begin
                        en_d   = wb_dat_i[0];
                        ien_d  = wb_dat_i[1];
                        auto_d = wb_dat_i[2];
                    end
`ifdef AEMB_TMR_PRESCALE_EN
                    if (wb_sel_i[1]) pre_d = wb_dat_i[15:8];
                    psc_d = 8'h00;
`endif
                end
                ADR_LOAD: load_d = CNT_W'(merge_lanes(32'(load_q), wb_dat_i, wb_sel_i));
                ADR_CNT:  cnt_d  = CNT_W'(merge_lanes(32'(cnt_q), wb_dat_i, wb_sel_i));
                default:  ;
            endcase
        end

        // Expiry sets PEND even when a clear lands on the same edge.
        pend_d = (pend_q & ~pend_clr) | expire;
        int_d  = pend_d & ien_d;
    end

    // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            int_q  <= 1'b0;
            en_q   <= 1'b0;
            ien_q  <= 1'b0;
            auto_q <= 1'b0;
            pend_q <= 1'b0;
            load_q <= RST_CNT;
            cnt_q  <= RST_CNT;
`ifdef AEMB_TMR_PRESCALE_EN
            pre_q  <= '0;
            psc_q  <= '0;
`endif
        end else begin
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            int_q  <= int_d;
            en_q   <= en_d;
            ien_q  <= ien_d;
            auto_q <= auto_d;
            pend_q <= pend_d;
            load_q <= load_d;
            cnt_q  <= cnt_d;
`ifdef AEMB_TMR_PRESCALE_EN
            pre_q  <= pre_d;
            psc_q  <= psc_d;
`endif
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
    assign sys_int_o = int_q;

endmodule

// File: tb/tb_aemb_wb_timer.sv
// Self-checking bench for aemb_wb_timer: register vector table, timing sequences and
// randomized count runs checked against closed-form expiry/count arithmetic.
module tb_aemb_wb_timer;

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_LOAD = 2'd1;
    localparam logic [1:0] A_CNT  = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;
`ifdef AEMB_TMR_PRESCALE_EN
    localparam bit PRE_ON = 1'b1;
`else
    localparam bit PRE_ON = 1'b0;
`endif

    logic        sys_clk_i = 1'b0;
    logic        sys_rst_i = 1'b0;
    logic        wb_cyc_i  = 1'b0;
    logic        wb_stb_i  = 1'b0;
    logic        wb_wre_i  = 1'b0;
    logic [3:0]  wb_sel_i  = 4'h0;
    logic [1:0]  wb_adr_i  = 2'd0;
    logic [31:0] wb_dat_i  = 32'h0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        sys_int_o;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int last_commit = 0;

    aemb_wb_timer dut (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_wre_i  (wb_wre_i),
        .wb_sel_i  (wb_sel_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .sys_int_o (sys_int_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;
    always @(posedge sys_clk_i) cycle++;

    typedef struct {
        logic        wre;
        logic [1:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where ack drops (write commit edge).
    task automatic bus(input logic wre, input logic [1:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdat, output int lat);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_wre_i = wre;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        lat  = -1;
        rdat = 32'hx;
        for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk_i);
            if (wb_ack_o) begin
                lat  = k;
                rdat = wb_dat_o;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout: no ack for adr %0d", adr);
        end
        @(posedge sys_clk_i);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_wre_i = 1'b0;
        last_commit = cycle;
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] d;
        int l;
        bus(1'b1, adr, dat, sel, d, l);
    endtask

    task automatic rd_chk(input string name, input logic [1:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        int l;
        bus(1'b0, adr, 32'h0, 4'h0, d, l);
        check(name, d, exp);
    endtask

    // Counts rising edges until sys_int_o is seen high.
    task automatic wait_int(input string name, input int exp_n);
        int n;
        n = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge sys_clk_i);
            #1;
            n++;
            if (sys_int_o) break;
        end
        check(name, 32'(n), 32'(exp_n));
    endtask

    // Count after n ticks from c0: down to 0, then (L+1)-periodic reload; one-shot stops at reload.
    function automatic logic [31:0] model_cnt(input int c0, input int ld, input bit am, input int n);
        int t;
        t = n;
        if (!am && t > c0 + 1) t = c0 + 1;
        if (t <= c0) return 32'(c0 - t);
        return 32'(ld - ((t - c0 - 1) % (ld + 1)));
    endfunction

    initial begin
        logic [31:0] d;
        int lat, c0, ld, w, e0, n;
        bit am;

        tbl[0]  = '{1'b1, A_CNT,  32'h1122_3344, 4'hF, 32'h0};
        tbl[1]  = '{1'b1, A_CNT,  32'hAABB_CCDD, 4'h3, 32'h0};
        tbl[2]  = '{1'b0, A_CNT,  32'h0,         4'h0, 32'h1122_CCDD};
        tbl[3]  = '{1'b1, A_CNT,  32'hFFFF_FFFF, 4'h0, 32'h0};
        tbl[4]  = '{1'b0, A_CNT,  32'h0,         4'h0, 32'h1122_CCDD};
        tbl[5]  = '{1'b0, A_LOAD, 32'h0,         4'h0, 32'h0000_7FFF};
        tbl[6]  = '{1'b1, A_LOAD, 32'h1234_5678, 4'hC, 32'h0};
        tbl[7]  = '{1'b0, A_LOAD, 32'h0,         4'h0, 32'h1234_7FFF};
        tbl[8]  = '{1'b1, A_CTRL, 32'hFFFF_FFF8, 4'hF, 32'h0};
        tbl[9]  = '{1'b0, A_CTRL, 32'h0,         4'h0, PRE_ON ? 32'h0000_FF00 : 32'h0};
        tbl[10] = '{1'b1, A_CTRL, 32'h0000_0006, 4'h1, 32'h0};
        tbl[11] = '{1'b0, A_CTRL, 32'h0,         4'h0, PRE_ON ? 32'h0000_FF06 : 32'h6};
        tbl[12] = '{1'b0, A_STAT, 32'h0,         4'h0, 32'h0};
        tbl[13] = '{1'b1, A_CTRL, 32'h0,         4'hF, 32'h0};
        tbl[14] = '{1'b0, A_CTRL, 32'h0,         4'h0, 32'h0};

        // Power-on reset
        #12;
        check("rst_ack", 32'(wb_ack_o), 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_int", 32'(sys_int_o), 32'h0);
        #10 sys_rst_i = 1'b1;
        @(posedge sys_clk_i);
        #1;

        // Register vector table (counter disabled)
        for (int i = 0; i < 15; i++) begin
            bus(tbl[i].wre, tbl[i].adr, tbl[i].dat, tbl[i].sel, d, lat);
            if (!tbl[i].wre) check($sformatf("vec%0d", i), d, tbl[i].exp);
        end

        // One-shot
        wr(A_LOAD, 32'd5, 4'hF);
        wr(A_CNT,  32'd5, 4'hF);
        wr(A_CTRL, 32'h3, 4'hF);
        wait_int("oneshot_edges", 6);
        rd_chk("oneshot_ctrl", A_CTRL, 32'h2);
        rd_chk("oneshot_cnt",  A_CNT,  32'd5);
        check("oneshot_int_held", 32'(sys_int_o), 32'h1);

        // Asynchronous reset in the middle of a write to LOAD
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_wre_i = 1'b1;
        wb_adr_i = A_LOAD; wb_dat_i = 32'hDEAD_BEEF; wb_sel_i = 4'hF;
        @(posedge sys_clk_i);
        #2;
        check("midrst_ack_pre", 32'(wb_ack_o), 32'h1);
        sys_rst_i = 1'b0;
        #1;
        check("midrst_ack", 32'(wb_ack_o), 32'h0);
        check("midrst_dat", wb_dat_o, 32'h0);
        check("midrst_int", 32'(sys_int_o), 32'h0);
        #3;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_wre_i = 1'b0;
        #1 sys_rst_i = 1'b1;
        @(posedge sys_clk_i);
        #1;
        bus(1'b0, A_LOAD, 32'h0, 4'h0, d, lat);
        check("rst_load", d, 32'h0000_7FFF);
        check("ack_latency", 32'(lat), 32'd1);
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        rd_chk("rst_stat", A_STAT, 32'h0);

        // Auto-reload with STAT clears, including a clear on the expiry edge
        wr(A_LOAD, 32'd3, 4'hF);
        wr(A_CNT,  32'd3, 4'hF);
        wr(A_CTRL, 32'h7, 4'hF);
        wait_int("auto_first", 4);
        wr(A_STAT, 32'h1, 4'h1);
        check("auto_cleared", 32'(sys_int_o), 32'h0);
        wait_int("auto_period", 2);
        @(posedge sys_clk_i); #1;
        @(posedge sys_clk_i); #1;
        wr(A_STAT, 32'h1, 4'h1);
        check("auto_clr_vs_set_int", 32'(sys_int_o), 32'h1);
        rd_chk("auto_clr_vs_set_stat", A_STAT, 32'h1);
        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_STAT, 32'h1, 4'h1);

        // CNT write on a tick edge, then decrement resumes
        wr(A_LOAD, 32'd1000, 4'hF);
        wr(A_CNT,  32'd500,  4'hF);
        wr(A_CTRL, 32'h1,    4'hF);
        wr(A_CNT,  32'd100,  4'hF);
        rd_chk("collide_cnt", A_CNT, 32'd100);
        wr(A_CTRL, 32'h0, 4'hF);
        rd_chk("collide_after", A_CNT, 32'd96);

        // PEND masked by IEN
        wr(A_CNT,  32'd0, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        @(posedge sys_clk_i); #1;
        rd_chk("mask_pend", A_STAT, 32'h1);
        check("mask_int_off", 32'(sys_int_o), 32'h0);
        wr(A_CTRL, 32'h2, 4'hF);
        check("mask_int_on", 32'(sys_int_o), 32'h1);
        wr(A_STAT, 32'h1, 4'h1);
        check("mask_int_clr", 32'(sys_int_o), 32'h0);

        // Prescaler
        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_LOAD, 32'd1, 4'hF);
        wr(A_CNT,  32'd1, 4'hF);
        wr(A_CTRL, 32'h0000_0307, 4'hF);
        if (PRE_ON) begin
            wait_int("presc_edges", 8);
            rd_chk("presc_ctrl", A_CTRL, 32'h0000_0307);
        end else begin
            wait_int("nopresc_edges", 2);
            rd_chk("nopresc_ctrl", A_CTRL, 32'h0000_0007);
        end
        wr(A_CTRL, 32'h0, 4'hF);

        // Randomized runs: stop after a random delay, compare CNT/PEND with closed-form model
        for (int it = 0; it < 25; it++) begin
            c0 = int'($urandom_range(0, 20));
            ld = int'($urandom_range(0, 9));
            am = 1'($urandom_range(0, 1));
            w  = int'($urandom_range(0, 30));
            wr(A_CTRL, 32'h0, 4'hF);
            wr(A_STAT, 32'h1, 4'h1);
            wr(A_LOAD, 32'(ld), 4'hF);
            wr(A_CNT,  32'(c0), 4'hF);
            wr(A_CTRL, {29'h0, am, 2'b11}, 4'hF);
            e0 = last_commit;
            repeat (w) begin
                @(posedge sys_clk_i);
                #1;
            end
            wr(A_CTRL, 32'h0, 4'hF);
            n = last_commit - e0;
            rd_chk($sformatf("rnd%0d_cnt", it), A_CNT, model_cnt(c0, ld, am, n));
            rd_chk($sformatf("rnd%0d_pend", it), A_STAT, (n >= c0 + 1) ? 32'h1 : 32'h0);
            check($sformatf("rnd%0d_int", it), 32'(sys_int_o), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
